// File: rtl/tank_level_if.sv
// Sensor/operator inputs and valve/alarm outputs of the tank fill controller.
// master = sensor/operator side, slave = controller side.
interface tank_level_if #(
  parameter int NLEV = 3
);
  localparam int CW = $clog2(NLEV + 1);

  logic [NLEV-1:0] lvl;
  logic            ack;
  logic            ve;
  logic            al;
  logic [2:0]      al_code;
  logic [CW-1:0]   lvl_cnt;

  modport master (
    output lvl,
    output ack,
    input  ve,
    input  al,
    input  al_code,
    input  lvl_cnt
  );

  modport slave (
    input  lvl,
    input  ack,
    output ve,
    output al,
    output al_code,
    output lvl_cnt
  );
endinterface

// File: rtl/tank_level_ctrl.sv
// Tank fill controller: sensor sync/debounce, level hysteresis valve FSM, alarms.
// Optional fill timeout is compiled in when TANK_FILL_TMO_EN is defined.
module tank_level_ctrl #(
  parameter int NLEV    = 3,
  parameter int DEB     = 4,
  parameter int ON_LVL  = 2,
  parameter int OFF_LVL = 3,
  parameter int LOW_AL  = 2,
  parameter int TMO     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  tank_level_if.slave bus
);
  localparam int CW = $clog2(NLEV + 1);
  localparam int DW = $clog2(DEB + 1);
  localparam logic [CW-1:0] ON_C  = CW'(ON_LVL);
  localparam logic [CW-1:0] OFF_C = CW'(OFF_LVL);
  localparam logic [CW-1:0] LOW_C = CW'(LOW_AL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FAULT = 2'd2
  } state_t;

  if (NLEV < 2 || DEB < 1 || ON_LVL < 1 || ON_LVL > OFF_LVL || OFF_LVL > NLEV || TMO < 1)
  begin : g_param_chk
    $error("tank_level_ctrl: illegal parameter combination");
  end

  logic [NLEV-1:0] deb_vec;

  // Per-sensor 2-FF synchroniser followed by a stability counter.
  generate
    for (genvar gi = 0; gi < NLEV; gi++) begin : g_sensor
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= bus.lvl[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEB - 1)) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign deb_vec[gi] = deb_reg;
    end
  endgenerate

  logic            pat_valid;
  logic [CW-1:0]   pop_cnt;
  logic [CW-1:0]   lvl_cnt_reg;
  logic [CW-1:0]   lvl_cnt_next;
  logic            lvl_inc;

  // Thermometer code from the bottom is 2^k-1, so x & (x+1) must be zero.
  assign pat_valid = ((deb_vec & (deb_vec + NLEV'(1))) == '0);

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NLEV; i++) begin
      pop_cnt = pop_cnt + CW'(deb_vec[i]);
    end
  end

  assign lvl_cnt_next = pat_valid ? pop_cnt : lvl_cnt_reg;
  assign lvl_inc      = (lvl_cnt_next > lvl_cnt_reg);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] sticky_reg;
  logic [1:0] sticky_next;
  logic       tmo_hit;
  logic       low_reg;
  logic       low_next;
  logic       ve_reg;
  logic       al_reg;

`ifdef TANK_FILL_TMO_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_reg;
  logic [TW-1:0] tmo_next;

  assign tmo_hit  = (state_reg == FILL) && !lvl_inc && (tmo_reg == TW'(TMO - 1));
  // Restart on entry, on any level rise, and whenever FILL is not being held.
  assign tmo_next = ((state_reg != FILL) || (state_next != FILL) || lvl_inc)
                    ? '0 : tmo_reg + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_next;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    sticky_next = sticky_reg;
    if (!pat_valid || tmo_hit) begin
      state_next = FAULT;
      if (!pat_valid) sticky_next[0] = 1'b1;
      if (tmo_hit)    sticky_next[1] = 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (lvl_cnt_reg < ON_C) state_next = FILL;
        end
        FILL: begin
          if (lvl_cnt_reg >= OFF_C) state_next = IDLE;
        end
        FAULT: begin
          if (bus.ack) begin
            state_next  = IDLE;
            sticky_next = 2'b00;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign low_next = (lvl_cnt_reg < LOW_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sticky_reg  <= 2'b00;
      lvl_cnt_reg <= '0;
      low_reg     <= 1'b0;
      ve_reg      <= 1'b0;
      al_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sticky_reg  <= sticky_next;
      lvl_cnt_reg <= lvl_cnt_next;
      low_reg     <= low_next;
      ve_reg      <= (state_next == FILL);
      al_reg      <= (state_next == FAULT) || low_next;
    end
  end

  assign bus.ve      = ve_reg;
  assign bus.al      = al_reg;
  assign bus.al_code = {low_reg, sticky_reg};
  assign bus.lvl_cnt = lvl_cnt_reg;

endmodule

// File: tb/tb_tank_level_ctrl.sv
// Scoreboard bench for tank_level_ctrl: a behavioural model pushes expected
// outputs per clock, an independent monitor pops and compares them.
module tb_tank_level_ctrl;
  localparam int NLEV    = 3;
  localparam int DEB     = 4;
  localparam int ON_LVL  = 2;
  localparam int OFF_LVL = 3;
  localparam int LOW_AL  = 2;
  localparam int TMO     = 16;
`ifdef TANK_FILL_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  tank_level_if #(.NLEV(NLEV)) bus ();

  tank_level_ctrl #(
    .NLEV(NLEV), .DEB(DEB), .ON_LVL(ON_LVL), .OFF_LVL(OFF_LVL),
    .LOW_AL(LOW_AL), .TMO(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int ve;
    int al;
    int code;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw sample history: index 0 is the value sampled on the current edge.
  logic [NLEV-1:0] hist [0:DEB+1];
  logic [NLEV-1:0] m_deb;
  int              m_cnt;
  int              m_st;     // 0 idle, 1 filling, 2 fault
  int              m_since;  // FILL edges since entry/last rise
  bit              m_s0, m_s1;

  function automatic int popc(input logic [NLEV-1:0] v);
    int n = 0;
    for (int i = 0; i < NLEV; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic bit is_therm(input logic [NLEV-1:0] v);
    return int'(v) == ((1 << popc(v)) - 1);
  endfunction

  task automatic model_step(input logic r, input logic [NLEV-1:0] v, input logic a);
    exp_t e;
    logic [NLEV-1:0] deb_o;
    int cnt_o, st_o, cnt_new, st_new;
    bit valid_o, grew, hit, low;
    if (r) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
      m_deb = '0; m_cnt = 0; m_st = 0; m_since = 0; m_s0 = 0; m_s1 = 0;
      e = '{0, 0, 0, 0};
      exp_q.push_back(e);
      return;
    end
    for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    deb_o = m_deb; cnt_o = m_cnt; st_o = m_st;
    // A bit flips once the synchronised value (two edges old) has opposed it DEB edges running.
    for (int b = 0; b < NLEV; b++) begin
      bit flip = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) if (hist[k][b] == deb_o[b]) flip = 1'b0;
      if (flip) m_deb[b] = ~deb_o[b];
    end
    valid_o = is_therm(deb_o);
    cnt_new = valid_o ? popc(deb_o) : cnt_o;
    grew    = cnt_new > cnt_o;
    hit     = TMO_EN && st_o == 1 && !grew && m_since == TMO - 1;
    st_new  = st_o;
    if (!valid_o || hit) begin
      st_new = 2;
      if (!valid_o) m_s0 = 1;
      if (hit) m_s1 = 1;
    end else if (st_o == 0 && cnt_o < ON_LVL) st_new = 1;
    else if (st_o == 1 && cnt_o >= OFF_LVL) st_new = 0;
    else if (st_o == 2 && a) begin
      st_new = 0; m_s0 = 0; m_s1 = 0;
    end
    m_since = (st_o == 1 && st_new == 1 && !grew) ? m_since + 1 : 0;
    low = cnt_o < LOW_AL;
    e.ve   = (st_new == 1);
    e.al   = (st_new == 2) || low;
    e.code = (int'(low) << 2) | (int'(m_s1) << 1) | int'(m_s0);
    e.cnt  = cnt_new;
    m_cnt = cnt_new;
    m_st  = st_new;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ve",      int'(bus.ve),      e.ve);
        chk("al",      int'(bus.al),      e.al);
        chk("al_code", int'(bus.al_code), e.code);
        chk("lvl_cnt", int'(bus.lvl_cnt), e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic seg(input logic r, input logic [NLEV-1:0] v, input logic a,
                     input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; bus.lvl = v; bus.ack = a;
      model_step(r, v, a);
    end
    $display("seg %-8s rst=%0b lvl=%b ack=%0b cycles=%0d", tag, r, v, a, n);
  endtask

  initial begin
    logic [NLEV-1:0] rv;
    int lv;
    rst = 1'b1; bus.lvl = '0; bus.ack = 1'b0;
    model_step(1'b1, '0, 1'b0);
    void'(exp_q.pop_front());

    // empty-tank start and filling
    seg(1, 3'b000, 0, 3,  "reset");
    seg(0, 3'b000, 0, 2,  "empty");
    seg(0, 3'b001, 0, 10, "lvl1");
    seg(0, 3'b011, 0, 10, "lvl2");
    seg(0, 3'b111, 0, 12, "full");
    // hysteresis
    seg(0, 3'b011, 0, 12, "drop2");
    seg(0, 3'b001, 0, 12, "drop1");
    seg(0, 3'b111, 0, 12, "refill");
    // glitch shorter than DEB
    seg(0, 3'b011, 0, DEB - 1, "glitch");
    seg(0, 3'b111, 0, 12, "steady");
    // invalid pattern and acknowledge
    seg(0, 3'b101, 0, 10, "invalid");
    seg(0, 3'b101, 1, 4,  "ack_bad");
    seg(0, 3'b111, 0, 10, "fixed");
    seg(0, 3'b111, 1, 3,  "ack_ok");
    seg(0, 3'b111, 0, 3,  "idle");
    // fill timeout
    seg(0, 3'b001, 0, 40, "stall");
    seg(0, 3'b001, 1, 6,  "ack_tmo");
    seg(0, 3'b000, 1, 12, "ack_empty");
    seg(0, 3'b000, 0, 4,  "fill");

    // asynchronous reset between edges while filling
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_ve",      int'(bus.ve),      0);
    chk("async_al",      int'(bus.al),      0);
    chk("async_al_code", int'(bus.al_code), 0);
    chk("async_lvl_cnt", int'(bus.lvl_cnt), 0);
    seg(1, 3'b000, 0, 2, "reset2");
    seg(0, 3'b000, 0, 4, "restart");

    for (int s = 0; s < 250; s++) begin
      lv = $urandom_range(0, NLEV);
      if ($urandom_range(0, 9) == 0) rv = NLEV'($urandom);
      else rv = NLEV'((1 << lv) - 1);
      seg(0, rv, ($urandom_range(0, 5) == 0), $urandom_range(1, 12), "rand");
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
